// File: rtl/noc_input_buffer.sv
// -----------------------------------------------------------------------------
// noc_input_buffer
//
// Per-port input FIFO of a mesh router. It sits directly upstream of the
// route-computation stage. Flits arrive from the neighbouring router's output
// link (or from the local core). The head flit is presented show-ahead to
// route computation and is popped on rc_ready. Occupancy is published as a
// registered pressure value. Neighbouring routers use that value for
// congestion-aware adaptive routing.
//
// Ports:
//   buf_clk         in   block clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   link_data_in    in   [DATASIZE-1:0] flit from the upstream link
//   link_valid_in   in   link_data_in valid this cycle
//   link_ready_out  out  buffer can accept a flit this cycle (!full)
//   data_out        out  [DATASIZE-1:0] head flit (show-ahead)
//   valid_out       out  head flit valid (!empty)
//   rc_ready        in   route computation consumes the head flit
//   pressure_out    out  [WIDTH:0] registered occupancy, 0..DEPTH
//   overflow_err    out  sticky: a flit was offered while full
// -----------------------------------------------------------------------------
module noc_input_buffer #(
    parameter int DEPTH    = 8,   // must equal 2**WIDTH
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40
) (
    input  logic                buf_clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] link_data_in,
    input  logic                link_valid_in,
    output logic                link_ready_out,
    output logic [DATASIZE-1:0] data_out,
    output logic                valid_out,
    input  logic                rc_ready,
    output logic [WIDTH:0]      pressure_out,
    output logic                overflow_err
);

    localparam logic [WIDTH:0]   DEPTH_C   = (WIDTH+1)'(DEPTH);
    localparam logic [WIDTH:0]   CNT_ONE   = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] PTR_ONE   = WIDTH'(1);

    logic [DATASIZE-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH:0]      count_q, count_d;
    logic [WIDTH:0]      pressure_q;
    logic                overflow_q, overflow_d;

    logic full, empty, push, pop;

    // Handshake flags come straight from the count register. They drop to
    // their reset values as soon as rst_n is asserted, without waiting for an edge.
    assign full           = (count_q == DEPTH_C);
    assign empty          = (count_q == '0);
    assign push           = link_valid_in && !full;
    assign pop            = !empty && rc_ready;

    assign link_ready_out = !full;
    assign valid_out      = !empty;
    assign data_out       = mem_q[rd_ptr_q];
    assign pressure_out   = pressure_q;
    assign overflow_err   = overflow_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;  // wraps naturally at DEPTH
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // An offer while full counts as an overflow even when a pop frees a slot
        // in the same cycle. The flit was not accepted, because ready was low.
        if (link_valid_in && full) overflow_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge buf_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pressure_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pressure_q <= count_d;   // registered copy of the next count
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array has no reset. Its contents are unobservable while empty, and leaving out the reset keeps it a plain register file.
    always_ff @(posedge buf_clk) begin
        if (push) mem_q[wr_ptr_q] <= link_data_in;
    end

endmodule

// File: tb/tb_noc_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_noc_input_buffer
//
// Self-checking bench for noc_input_buffer. It combines a table of directed
// vectors, hand-written corner sequences and a randomized phase. Expectations
// in the random phase come from a queue-based FIFO model.
// -----------------------------------------------------------------------------
module tb_noc_input_buffer;

    localparam int DEPTH    = 8;
    localparam int WIDTH    = 3;
    localparam int DATASIZE = 40;

    logic                buf_clk = 1'b0;
    logic                rst_n;
    logic [DATASIZE-1:0] link_data_in;
    logic                link_valid_in;
    logic                link_ready_out;
    logic [DATASIZE-1:0] data_out;
    logic                valid_out;
    logic                rc_ready;
    logic [WIDTH:0]      pressure_out;
    logic                overflow_err;

    noc_input_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DATASIZE)) dut (
        .buf_clk        (buf_clk),
        .rst_n          (rst_n),
        .link_data_in   (link_data_in),
        .link_valid_in  (link_valid_in),
        .link_ready_out (link_ready_out),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .rc_ready       (rc_ready),
        .pressure_out   (pressure_out),
        .overflow_err   (overflow_err)
    );

    always #5 buf_clk = ~buf_clk;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model: a plain queue of flits plus a sticky overflow flag.
    logic [DATASIZE-1:0] model_q [$];
    logic                model_ovf;

    typedef struct {
        logic                valid;
        logic [DATASIZE-1:0] data;
        logic                rdy;
        logic                exp_valid;
        logic [DATASIZE-1:0] exp_data;   // compared only when exp_valid
        logic                exp_ready;
        logic [WIDTH:0]      exp_pressure;
        logic                exp_ovf;
    } vec_t;

    vec_t table_q [$];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic void add_vec(input logic v, input logic [DATASIZE-1:0] d, input logic r,
                                    input logic ev, input logic [DATASIZE-1:0] ed, input logic er,
                                    input int ep, input logic eo);
        vec_t t;
        t.valid = v; t.data = d; t.rdy = r;
        t.exp_valid = ev; t.exp_data = ed; t.exp_ready = er;
        t.exp_pressure = (WIDTH+1)'(ep); t.exp_ovf = eo;
        table_q.push_back(t);
    endfunction

    // Inputs are driven at the negedge. The model is advanced at the posedge.
    // Control returns at the next negedge, where the outputs are sampled.
    task automatic step(input logic v, input logic [DATASIZE-1:0] d, input logic r);
        logic full_m, pop_m;
        link_valid_in = v;
        link_data_in  = d;
        rc_ready      = r;
        @(posedge buf_clk);
        full_m = (model_q.size() == DEPTH);
        pop_m  = (model_q.size() != 0) && r;
        if (v && full_m) model_ovf = 1'b1;
        if (pop_m) void'(model_q.pop_front());
        if (v && !full_m) model_q.push_back(d);
        @(negedge buf_clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"},    64'(valid_out),      64'(model_q.size() != 0));
        check({tag, ".ready"},    64'(link_ready_out), 64'(model_q.size() != DEPTH));
        check({tag, ".pressure"}, 64'(pressure_out),   64'(model_q.size()));
        check({tag, ".ovf"},      64'(overflow_err),   64'(model_ovf));
        if (model_q.size() != 0)
            check({tag, ".data"}, 64'(data_out), 64'(model_q[0]));
    endtask

    task automatic do_reset();
        link_valid_in = 1'b0;
        link_data_in  = '0;
        rc_ready      = 1'b0;
        rst_n         = 1'b0;
        model_q.delete();
        model_ovf     = 1'b0;
        #12;
        @(negedge buf_clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [DATASIZE-1:0] rand_flit();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DATASIZE-1:0];
    endfunction

    initial begin
        // ---------------- directed table ----------------
        add_vec(1, 40'h01_0000_00AA, 1, 1, 40'h01_0000_00AA, 1, 1, 0); // rc_ready while empty ignored
        add_vec(0, '0, 1, 0, '0, 1, 0, 0);                              // popped
        add_vec(0, '0, 0, 0, '0, 1, 0, 0);                              // idle
        for (int i = 0; i < 8; i++)
            add_vec(1, DATASIZE'(i), 0, 1, '0, (i < 7), i + 1, 0);      // fill, head stays flit 0
        add_vec(1, 40'h99, 0, 1, '0, 0, 8, 1);                          // 9th flit dropped
        for (int i = 0; i < 8; i++)
            add_vec(0, '0, 1, (i < 7), DATASIZE'(i + 1), 1, 7 - i, 1);  // drain in order

        // ---------------- reset state ----------------
        do_reset();
        check("rst.valid",    64'(valid_out),      64'(0));
        check("rst.ready",    64'(link_ready_out), 64'(1));
        check("rst.pressure", 64'(pressure_out),   64'(0));
        check("rst.ovf",      64'(overflow_err),   64'(0));

        foreach (table_q[k]) begin
            step(table_q[k].valid, table_q[k].data, table_q[k].rdy);
            check($sformatf("tbl%0d.valid", k),    64'(valid_out),      64'(table_q[k].exp_valid));
            check($sformatf("tbl%0d.ready", k),    64'(link_ready_out), 64'(table_q[k].exp_ready));
            check($sformatf("tbl%0d.pressure", k), 64'(pressure_out),   64'(table_q[k].exp_pressure));
            check($sformatf("tbl%0d.ovf", k),      64'(overflow_err),   64'(table_q[k].exp_ovf));
            if (table_q[k].exp_valid)
                check($sformatf("tbl%0d.data", k), 64'(data_out), 64'(table_q[k].exp_data));
        end

        // ---------------- wrap-around ----------------
        do_reset();
        for (int i = 0; i < 6; i++) begin step(1, rand_flit(), 0); check_model("wrapA"); end
        for (int i = 0; i < 6; i++) begin step(0, '0, 1);          check_model("wrapB"); end
        for (int i = 0; i < 5; i++) begin
            step(1, rand_flit(), 0); check_model("wrapC");
            check("wrap.bound", 64'(pressure_out <= 5), 64'(1));
        end
        for (int i = 0; i < 5; i++) begin step(0, '0, 1);          check_model("wrapD"); end

        // ---------------- simultaneous push/pop at count 3 ----------------
        for (int i = 0; i < 3; i++) begin step(1, rand_flit(), 0); check_model("simA"); end
        for (int i = 0; i < 10; i++) begin
            step(1, rand_flit(), 1); check_model("simB");
            check("sim.pressure3", 64'(pressure_out), 64'(3));
        end

        // ---------------- full with simultaneous pop: offer dropped ----------------
        for (int i = 0; i < 5; i++) begin step(1, rand_flit(), 0); check_model("fullA"); end
        check("full.ready0", 64'(link_ready_out), 64'(0));
        step(1, 40'hDE_AD00_BEEF, 1);
        check("fullpop.pressure", 64'(pressure_out),   64'(7));
        check("fullpop.ovf",      64'(overflow_err),   64'(1));
        check("fullpop.ready",    64'(link_ready_out), 64'(1));
        check_model("fullB");

        // ---------------- reset mid-burst at count 5 ----------------
        for (int i = 0; i < 2; i++) begin step(0, '0, 1); check_model("preRst"); end
        check("prerst.pressure5", 64'(pressure_out), 64'(5));
        rst_n = 1'b0;
        #1;
        check("midrst.valid",    64'(valid_out),      64'(0));
        check("midrst.pressure", 64'(pressure_out),   64'(0));
        check("midrst.ready",    64'(link_ready_out), 64'(1));
        check("midrst.ovf",      64'(overflow_err),   64'(0));
        do_reset();
        step(1, 40'h55_1234_5678, 0);
        check("postrst.data",     64'(data_out),     64'(40'h55_1234_5678));
        check("postrst.pressure", 64'(pressure_out), 64'(1));
        model_q.delete();
        model_q.push_back(40'h55_1234_5678);

        // ---------------- randomized phase against the queue model ----------------
        // Phases bias push/pop probability so both full and empty are visited.
        for (int n = 0; n < 600; n++) begin
            int pv, pr;
            case ((n / 50) % 3)
                0:       begin pv = 80; pr = 30; end
                1:       begin pv = 30; pr = 80; end
                default: begin pv = 60; pr = 60; end
            endcase
            step(($urandom_range(99) < pv), rand_flit(), ($urandom_range(99) < pr));
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
